// File: rtl/logic_pod_pkg.sv
// Shared types for the logic pod capture path: phase-shifter FSM states
// and the 5-bit IDELAYE2 tap type.
package logic_pod_pkg;

  typedef enum logic [2:0] {
    INIT_LOAD = 3'd0,
    IDLE      = 3'd1,
    STEP      = 3'd2,
    SETTLE    = 3'd3,
    VERIFY    = 3'd4,
    RELOAD    = 3'd5,
    DONE      = 3'd6
  } phase_shifter_state_t;

  typedef logic [4:0] tap_t;

endpackage

// File: rtl/logic_pod_idelay_phase_shifter.sv
// MMCM-style dynamic phase-shift responder that steps one IDELAYE2 tap per
// request, with circular tap position and readback verification.
module logic_pod_idelay_phase_shifter
  import logic_pod_pkg::*;
#(
  parameter int unsigned NUM_TAPS      = 32,
  parameter int unsigned INIT_TAP      = 0,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic       clk_312p5mhz,
  input  logic       rst,
  input  logic       phase_shift_en,
  input  logic       phase_shift_inc,
  output logic       phase_shift_done,
  output logic       idelay_ld,
  output logic       idelay_ce,
  output logic       idelay_inc,
  output logic [4:0] idelay_cntvaluein,
  input  logic [4:0] idelay_cntvalueout,
  output logic [4:0] tap,
  output logic       wrapped,
  output logic       busy,
  output logic       err_protocol,
  output logic       err_readback
);

  localparam tap_t       MAX_TAP     = tap_t'(NUM_TAPS - 32'd1);
  localparam tap_t       INIT_TAP_T  = tap_t'(INIT_TAP);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 32'd1);

  phase_shifter_state_t state_r, state_s;
  logic [7:0] settle_cnt_r, settle_cnt_s;
  tap_t       tap_r, tap_s;
  tap_t       cntvaluein_r, cntvaluein_s;
  logic       wrap_r, wrap_s;
  logic       retried_r, retried_s;
  logic       init_r, init_s;
  logic       ld_r, ld_s;
  logic       ce_r, ce_s;
  logic       inc_r, inc_s;
  logic       done_r, done_s;
  logic       wrapped_r, wrapped_s;
  logic       busy_r, busy_s;
  logic       err_protocol_r, err_protocol_s;
  logic       err_readback_r, err_readback_s;
  logic       accepting_s;

  // Next-state, next-output and bookkeeping logic for the phase-shift FSM.
  always_comb begin
    state_s        = state_r;
    settle_cnt_s   = settle_cnt_r;
    tap_s          = tap_r;
    cntvaluein_s   = cntvaluein_r;
    wrap_s         = wrap_r;
    retried_s      = retried_r;
    init_s         = init_r;
    ld_s           = 1'b0;
    ce_s           = 1'b0;
    inc_s          = 1'b0;
    done_s         = 1'b0;
    wrapped_s      = 1'b0;
    err_protocol_s = err_protocol_r;
    err_readback_s = err_readback_r;
    // DONE behaves like IDLE for acceptance so back-to-back steps need no gap
    accepting_s    = (state_r == IDLE) || (state_r == DONE);

    case (state_r)
      INIT_LOAD: begin
        // First cycle registers the LD pulse, second cycle is the pulse itself
        if (!ld_r) begin
          ld_s         = 1'b1;
          cntvaluein_s = INIT_TAP_T;
        end else begin
          state_s      = SETTLE;
          settle_cnt_s = SETTLE_LAST;
        end
      end
      IDLE, DONE: begin
        if (phase_shift_en) begin
          state_s   = STEP;
          retried_s = 1'b0;
          if (phase_shift_inc && (tap_r == MAX_TAP)) begin
            ld_s         = 1'b1;
            cntvaluein_s = 5'd0;
            tap_s        = 5'd0;
            wrap_s       = 1'b1;
          end else if (!phase_shift_inc && (tap_r == 5'd0)) begin
            ld_s         = 1'b1;
            cntvaluein_s = MAX_TAP;
            tap_s        = MAX_TAP;
            wrap_s       = 1'b1;
          end else begin
            ce_s   = 1'b1;
            inc_s  = phase_shift_inc;
            tap_s  = phase_shift_inc ? (tap_r + 5'd1) : (tap_r - 5'd1);
            wrap_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      STEP, RELOAD: begin
        state_s      = SETTLE;
        settle_cnt_s = SETTLE_LAST;
      end
      SETTLE: begin
        if (settle_cnt_r == 8'd0) begin
          state_s = VERIFY;
        end else begin
          settle_cnt_s = settle_cnt_r - 8'd1;
        end
      end
      VERIFY: begin
        if ((idelay_cntvalueout == tap_r) || retried_r) begin
          if (idelay_cntvalueout != tap_r) begin
            err_readback_s = 1'b1;
          end else begin
            err_readback_s = err_readback_r;
          end
          retried_s = 1'b0;
          wrap_s    = 1'b0;
          // The init load completes silently
          if (init_r) begin
            state_s = IDLE;
            init_s  = 1'b0;
          end else begin
            state_s   = DONE;
            done_s    = 1'b1;
            wrapped_s = wrap_r;
          end
        end else begin
          state_s      = RELOAD;
          retried_s    = 1'b1;
          ld_s         = 1'b1;
          cntvaluein_s = tap_r;
        end
      end
      default: begin
        state_s = INIT_LOAD;
        init_s  = 1'b1;
      end
    endcase

    if (phase_shift_en && !accepting_s) begin
      err_protocol_s = 1'b1;
    end else begin
      err_protocol_s = err_protocol_s;
    end

    busy_s = !((state_s == IDLE) || (state_s == DONE));
  end

  // FSM state register.
  always_ff @(posedge clk_312p5mhz or posedge rst) begin
    if (rst) begin
      state_r <= INIT_LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered datapath, flags and all module outputs.
  always_ff @(posedge clk_312p5mhz or posedge rst) begin
    if (rst) begin
      settle_cnt_r   <= 8'd0;
      tap_r          <= INIT_TAP_T;
      cntvaluein_r   <= INIT_TAP_T;
      wrap_r         <= 1'b0;
      retried_r      <= 1'b0;
      init_r         <= 1'b1;
      ld_r           <= 1'b0;
      ce_r           <= 1'b0;
      inc_r          <= 1'b0;
      done_r         <= 1'b0;
      wrapped_r      <= 1'b0;
      busy_r         <= 1'b1;
      err_protocol_r <= 1'b0;
      err_readback_r <= 1'b0;
    end else begin
      settle_cnt_r   <= settle_cnt_s;
      tap_r          <= tap_s;
      cntvaluein_r   <= cntvaluein_s;
      wrap_r         <= wrap_s;
      retried_r      <= retried_s;
      init_r         <= init_s;
      ld_r           <= ld_s;
      ce_r           <= ce_s;
      inc_r          <= inc_s;
      done_r         <= done_s;
      wrapped_r      <= wrapped_s;
      busy_r         <= busy_s;
      err_protocol_r <= err_protocol_s;
      err_readback_r <= err_readback_s;
    end
  end

  assign phase_shift_done  = done_r;
  assign idelay_ld         = ld_r;
  assign idelay_ce         = ce_r;
  assign idelay_inc        = inc_r;
  assign idelay_cntvaluein = cntvaluein_r;
  assign tap               = tap_r;
  assign wrapped           = wrapped_r;
  assign busy              = busy_r;
  assign err_protocol      = err_protocol_r;
  assign err_readback      = err_readback_r;

endmodule
